// File: rtl/sm_adder_arbiter.sv
// Round-robin front end that time-shares one sign-magnitude adder between NUM_REQ requesters.
// Optional macro SM_NEG_ZERO_NORM_EN: stores a captured negative zero as all-zero.
module sm_adder_arbiter #(
  parameter int DATA_WIDTH  = 4,
  parameter int NUM_REQ     = 4,
  parameter int ROM_LATENCY = 1,
  parameter int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic [DATA_WIDTH-1:0]         adder_a,
  output logic [DATA_WIDTH-1:0]         adder_b,
  input  logic [DATA_WIDTH:0]           adder_sum,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [ID_W-1:0]               resp_id,
  output logic [DATA_WIDTH:0]           resp_sum
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam int CNT_W = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((ROM_LATENCY > 0) ? ROM_LATENCY - 1 : 0);

  logic [1:0]            r_state;
  logic [ID_W-1:0]       r_rr_ptr;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_adder_a;
  logic [DATA_WIDTH-1:0] r_adder_b;
  logic [ID_W-1:0]       r_resp_id;
  logic [DATA_WIDTH:0]   r_resp_sum;

  logic                  w_found;
  logic [ID_W-1:0]       w_grant_id;
  logic [DATA_WIDTH-1:0] w_sel_a;
  logic [DATA_WIDTH-1:0] w_sel_b;
  logic [DATA_WIDTH:0]   w_capture;

  // Scan offsets from the highest down so the smallest offset from rr_ptr wins.
  always_comb begin
    w_found    = 1'b0;
    w_grant_id = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin : g_scan
      int idx;
      idx = (int'(r_rr_ptr) + k) % NUM_REQ;
      if (req_valid[idx]) begin
        w_found    = 1'b1;
        w_grant_id = ID_W'(idx);
      end
    end
  end

  assign w_sel_a = req_a[w_grant_id*DATA_WIDTH +: DATA_WIDTH];
  assign w_sel_b = req_b[w_grant_id*DATA_WIDTH +: DATA_WIDTH];

`ifdef SM_NEG_ZERO_NORM_EN
  assign w_capture = (adder_sum[DATA_WIDTH-1:0] == '0) ? '0 : adder_sum;
`else
  assign w_capture = adder_sum;
`endif

  assign req_ready  = (r_state == S_IDLE && w_found) ? (NUM_REQ'(1) << w_grant_id) : '0;
  assign resp_valid = (r_state == S_RESP);
  assign adder_a    = r_adder_a;
  assign adder_b    = r_adder_b;
  assign resp_id    = r_resp_id;
  assign resp_sum   = r_resp_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= '0;
      r_cnt      <= '0;
      r_adder_a  <= '0;
      r_adder_b  <= '0;
      r_resp_id  <= '0;
      r_resp_sum <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_adder_a <= w_sel_a;
            r_adder_b <= w_sel_b;
            r_resp_id <= w_grant_id;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (ROM_LATENCY > 0) begin
            r_cnt   <= CNT_LOAD;
            r_state <= S_WAIT;
          end else begin
            r_resp_sum <= w_capture;
            r_state    <= S_RESP;
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_resp_sum <= w_capture;
            r_state    <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          if (resp_ready) begin
            r_rr_ptr <= (r_resp_id == ID_W'(NUM_REQ - 1)) ? '0 : r_resp_id + 1'b1;
            r_state  <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sm_adder_arbiter.sv
// Directed bench for sm_adder_arbiter with a behavioural one-stage sign-magnitude adder.
module tb_sm_adder_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_ready;
  logic [15:0] req_a = '0;
  logic [15:0] req_b = '0;
  logic [3:0]  adder_a;
  logic [3:0]  adder_b;
  logic [4:0]  adder_sum = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [1:0]  resp_id;
  logic [4:0]  resp_sum;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sm_adder_arbiter #(.DATA_WIDTH(4), .NUM_REQ(4), .ROM_LATENCY(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .adder_a(adder_a), .adder_b(adder_b), .adder_sum(adder_sum),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_sum(resp_sum)
  );

  function automatic logic [4:0] sm_add(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] ma, mb;
    ma = {1'b0, a[2:0]};
    mb = {1'b0, b[2:0]};
    if (a[3] == b[3]) return {a[3], ma + mb};
    if (ma > mb) return {a[3], ma - mb};
    if (mb > ma) return {b[3], mb - ma};
    return 5'b0;
  endfunction

  // One registered stage, matching ROM_LATENCY=1.
  always @(posedge clk) adder_sum <= sm_add(adder_a, adder_b);

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic run_txn(input string tag, input logic [3:0] mask, input logic [15:0] a_pk,
                         input logic [15:0] b_pk, input logic hold, input int exp_id,
                         input logic [4:0] exp_sum);
    int k;
    int t0;
    req_valid = mask;
    req_a     = a_pk;
    req_b     = b_pk;
    #1;
    k = 0;
    while (req_ready == 4'b0 && k < 20) begin
      @(negedge clk); #1; k++;
    end
    check({tag, " grant"}, 32'(req_ready), 32'(1 << exp_id));
    t0 = cyc;
    @(negedge clk);
    req_valid = hold ? mask : 4'b0;
    #1;
    k = 0;
    while (!resp_valid && k < 20) begin
      @(negedge clk); #1; k++;
    end
    check({tag, " latency"}, 32'(cyc - t0), 32'd3);
    check({tag, " sum"}, 32'(resp_sum), 32'(exp_sum));
    check({tag, " id"}, 32'(resp_id), 32'(exp_id));
    $display("txn %s: id=%0d sum=%b latency=%0d", tag, resp_id, resp_sum, cyc - t0);
    @(negedge clk); #1;
    check({tag, " valid drop"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic seen;

    @(negedge clk); #1;
    check("rst resp_valid", 32'(resp_valid), 32'd0);
    check("rst resp_sum", 32'(resp_sum), 32'd0);
    check("rst resp_id", 32'(resp_id), 32'd0);
    check("rst adder_a", 32'(adder_a), 32'd0);
    check("rst adder_b", 32'(adder_b), 32'd0);
    check("rst req_ready", 32'(req_ready), 32'd0);
    @(negedge clk); rst_n = 1'b1; #1;
    check("idle no req", 32'(req_ready), 32'd0);

    run_txn("single r0", 4'b0001, 16'h0004, 16'h0001, 1'b0, 0, 5'b00101);
    run_txn("mixed r1", 4'b0010, 16'h0040, 16'h0090, 1'b0, 1, 5'b00011);
    run_txn("mixed r2", 4'b0100, 16'h0F00, 16'h0100, 1'b0, 2, 5'b10110);
    run_txn("mixed r3", 4'b1000, 16'h9000, 16'hA000, 1'b0, 3, 5'b10011);

    run_txn("rr 0", 4'b1111, 16'hFFFF, 16'hEEEE, 1'b1, 0, 5'b11101);
    run_txn("rr 1", 4'b1111, 16'hFFFF, 16'hEEEE, 1'b1, 1, 5'b11101);
    run_txn("rr 2", 4'b1111, 16'hFFFF, 16'hEEEE, 1'b1, 2, 5'b11101);
    run_txn("rr 3", 4'b1111, 16'hFFFF, 16'hEEEE, 1'b1, 3, 5'b11101);
    run_txn("rr wrap", 4'b1111, 16'hFFFF, 16'hEEEE, 1'b0, 0, 5'b11101);

    // Backpressure: requester 1 served with resp_ready low, requester 2 waiting.
    resp_ready = 1'b0;
    req_valid  = 4'b0010;
    req_a      = 16'h0440;
    req_b      = 16'h0910;
    #1;
    check("bp grant", 32'(req_ready), 32'h2);
    @(negedge clk);
    req_valid = 4'b0100;
    #1;
    k = 0;
    while (!resp_valid && k < 20) begin
      @(negedge clk); #1; k++;
    end
    for (int i = 0; i < 5; i++) begin
      check("bp valid", 32'(resp_valid), 32'd1);
      check("bp sum", 32'(resp_sum), 32'h05);
      check("bp id", 32'(resp_id), 32'd1);
      check("bp no grant", 32'(req_ready), 32'd0);
      @(negedge clk); #1;
    end
    $display("txn bp r1: id=%0d sum=%b held 5 cycles", resp_id, resp_sum);
    resp_ready = 1'b1;
    @(negedge clk); #1;
    check("bp release valid", 32'(resp_valid), 32'd0);
    check("bp next grant", 32'(req_ready), 32'h4);
    run_txn("bp next r2", 4'b0100, 16'h0440, 16'h0910, 1'b0, 2, 5'b00011);

    // Asynchronous reset while the transaction from requester 3 sits in WAIT.
    req_valid = 4'b1000;
    req_a     = 16'h4000;
    req_b     = 16'h1000;
    #1;
    check("rstmid grant", 32'(req_ready), 32'h8);
    @(negedge clk);
    req_valid = 4'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid resp_valid", 32'(resp_valid), 32'd0);
    check("rstmid resp_id", 32'(resp_id), 32'd0);
    check("rstmid resp_sum", 32'(resp_sum), 32'd0);
    check("rstmid adder_a", 32'(adder_a), 32'd0);
    check("rstmid adder_b", 32'(adder_b), 32'd0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      if (resp_valid) seen = 1'b1;
    end
    check("rstmid no resp", 32'(seen), 32'd0);
    $display("txn rstmid r3: dropped by reset");
    run_txn("rst rr r2", 4'b1100, 16'h4400, 16'h9900, 1'b0, 2, 5'b00011);

`ifdef SM_NEG_ZERO_NORM_EN
    run_txn("negzero r0", 4'b0001, 16'h0008, 16'h0008, 1'b0, 0, 5'b00000);
`else
    run_txn("negzero r0", 4'b0001, 16'h0008, 16'h0008, 1'b0, 0, 5'b10000);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
